otp_array_model: RTL and testbench

- Synthesizable responder model of the A x B OTP fuse array and its sense/verify circuitry.
- Sits on the far side of the OTP controller's bias bus. It decodes PL/BL/WLN/WLP/PRG into cell-select events and stores one fuse bit per cell.
- It returns output_read_circuit and writing_successful to the controller.
- Used as the array stand-in for controller benches and for FPGA bring-up.

---
 rtl/otp_pkg.sv | 45 ++++
 rtl/otp_bias_decoder.sv | 49 ++++
 rtl/otp_array_model.sv | 184 ++++++++++++++++++
 tb/tb_otp_array_model.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared bias-bus encodings and state type for the OTP controller and the
// OTP array responder model.
package otp_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_READ  = 2'd1;
  localparam logic [1:0] MODE_WRITE = 2'd2;

  localparam logic BL_V_GND = 1'b0;
  localparam logic BL_V_MID = 1'b1;

  localparam logic [1:0] PL_V_GND  = 2'b00;
  localparam logic [1:0] PL_V_MID  = 2'b01;
  localparam logic [1:0] PL_V_READ = 2'b10;
  localparam logic [1:0] PL_V_HIGH = 2'b11;

  localparam logic WLN_V_MID = 1'b0;
  localparam logic WLN_V_GND = 1'b1;

  localparam logic WLP_V_HIGH = 1'b0;
  localparam logic WLP_V_MID  = 1'b1;

  localparam logic PRG_READ  = 1'b0;
  localparam logic PRG_WRITE = 1'b1;

  localparam logic READ_ZERO = 1'b0;
  localparam logic READ_ONE  = 1'b1;

  localparam logic WRITING_PENDING = 1'b0;
  localparam logic WRITING_DONE    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROG    = 3'd1,
    ST_PROG_OK = 3'd2,
    ST_READ    = 3'd3,
    ST_FAULT   = 3'd4
  } otp_array_state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otp_bias_decoder.sv
// Combinational decode of the bias bus into per-cell write/read selects,
// a saturated select count and the coordinates of the (single) selected cell.
module otp_bias_decoder
  import otp_pkg::*;
#(
  parameter int A = 2,
  parameter int B = 2,
  localparam int RW = idx_width(A),
  localparam int CW = idx_width(B)
) (
  input  logic              PRG,
  input  logic [2*B-1:0]    PL,
  input  logic [B-1:0]      BL,
  input  logic [A-1:0]      WLN,
  input  logic [A-1:0]      WLP,
  output logic [A*B-1:0]    write_sel,
  output logic [A*B-1:0]    read_sel,
  output logic [1:0]        nsel,
  output logic [RW-1:0]     sel_row,
  output logic [CW-1:0]     sel_col
);

  logic hit_s;

  // Per-cell select match, count of matching cells and last-match coordinates
  always_comb begin
    write_sel = '0;
    read_sel  = '0;
    nsel      = 2'd0;
    sel_row   = '0;
    sel_col   = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < A; i++) begin
      for (int j = 0; j < B; j++) begin
        write_sel[i*B+j] = (PRG == PRG_WRITE) && (WLP[i] == WLP_V_HIGH) &&
                           (WLN[i] == WLN_V_MID) && (BL[j] == BL_V_GND) &&
                           (PL[2*j +: 2] == PL_V_HIGH);
        read_sel[i*B+j]  = (PRG == PRG_READ) && (WLP[i] == WLP_V_MID) &&
                           (WLN[i] == WLN_V_MID) && (BL[j] == BL_V_MID) &&
                           (PL[2*j +: 2] == PL_V_READ);
        hit_s   = write_sel[i*B+j] || read_sel[i*B+j];
        nsel    = (hit_s && (nsel != 2'd2)) ? (nsel + 2'd1) : nsel;
        sel_row = hit_s ? RW'(i) : sel_row;
        sel_col = hit_s ? CW'(j) : sel_col;
      end
    end
  end

endmodule

// File: rtl/otp_array_model.sv
// Responder model of the A x B OTP fuse array: decodes bias patterns into
// program/read events, holds one sticky fuse bit per cell and reports status.
module otp_array_model
  import otp_pkg::*;
#(
  parameter int A           = 2,
  parameter int B           = 2,
  parameter int PROG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*B-1:0]    PL,
  input  logic [B-1:0]      BL,
  input  logic [A-1:0]      WLN,
  input  logic [A-1:0]      WLP,
  input  logic              PRG,
  output logic              output_read_circuit,
  output logic              writing_successful,
  output logic              prog_abort,
  output logic              illegal_bias,
  output logic [A*B-1:0]    fuse_state
);

  localparam int RW   = idx_width(A);
  localparam int CLW  = idx_width(B);
  localparam int IW   = idx_width(A*B);
  localparam int CNTW = $clog2(PROG_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(PROG_CYCLES);
  localparam logic [CNTW-1:0] PROG_LAST = CNTW'(PROG_CYCLES - 1);

  logic [A*B-1:0]   write_sel_s, read_sel_s;
  logic [1:0]       nsel_s;
  logic [RW-1:0]    sel_row_s;
  logic [CLW-1:0]   sel_col_s;
  logic [IW-1:0]    sel_idx_s, lat_idx_s;
  logic             single_write_s, single_read_s, same_write_s;

  otp_array_state_t state_r, state_s, idle_state_s;
  logic [RW-1:0]    row_r, row_s;
  logic [CLW-1:0]   col_r, col_s;
  logic [CNTW-1:0]  cnt_r, cnt_s, idle_cnt_s;
  logic [A*B-1:0]   fuse_r, fuse_s, idle_fuse_s;
  logic             orc_r, orc_s, idle_orc_s;
  logic             ws_r, ws_s, idle_ws_s;
  logic             pa_r, pa_s;
  logic             ib_r, ib_s;

  otp_bias_decoder #(.A(A), .B(B)) u_decoder (
    .PRG       (PRG),
    .PL        (PL),
    .BL        (BL),
    .WLN       (WLN),
    .WLP       (WLP),
    .write_sel (write_sel_s),
    .read_sel  (read_sel_s),
    .nsel      (nsel_s),
    .sel_row   (sel_row_s),
    .sel_col   (sel_col_s)
  );

  assign sel_idx_s      = IW'(sel_row_s) * IW'(B) + IW'(sel_col_s);
  assign lat_idx_s      = IW'(row_r) * IW'(B) + IW'(col_r);
  assign single_write_s = (nsel_s == 2'd1) && (|write_sel_s);
  assign single_read_s  = (nsel_s == 2'd1) && (|read_sel_s);
  assign same_write_s   = (nsel_s == 2'd1) && write_sel_s[lat_idx_s];

  // Outcome of a fresh bias pattern, shared by IDLE and READ (READ behaves as IDLE)
  always_comb begin
    idle_state_s = ST_IDLE;
    idle_cnt_s   = '0;
    idle_fuse_s  = fuse_r;
    idle_ws_s    = WRITING_PENDING;
    idle_orc_s   = READ_ZERO;
    if (nsel_s == 2'd2) begin
      idle_state_s = ST_FAULT;
    end else if (single_write_s) begin
      if (PROG_CYCLES == 1) begin
        idle_fuse_s[sel_idx_s] = 1'b1;
        idle_state_s           = ST_PROG_OK;
        idle_ws_s              = WRITING_DONE;
      end else begin
        idle_state_s = ST_PROG;
        idle_cnt_s   = CNTW'(1);
      end
    end else if (single_read_s) begin
      idle_state_s = ST_READ;
      idle_orc_s   = fuse_r[sel_idx_s];
    end else begin
      idle_state_s = ST_IDLE;
    end
  end

  // Next-state and next-output selection for the array state machine
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    cnt_s   = '0;
    fuse_s  = fuse_r;
    orc_s   = READ_ZERO;
    ws_s    = WRITING_PENDING;
    pa_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_READ: begin
        state_s = idle_state_s;
        row_s   = sel_row_s;
        col_s   = sel_col_s;
        cnt_s   = idle_cnt_s;
        fuse_s  = idle_fuse_s;
        orc_s   = idle_orc_s;
        ws_s    = idle_ws_s;
      end
      ST_PROG: begin
        if (same_write_s) begin
          if (cnt_r == PROG_LAST) begin
            fuse_s[lat_idx_s] = 1'b1;
            state_s           = ST_PROG_OK;
            ws_s              = WRITING_DONE;
          end else begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNTW'(1));
          end
        end else if (nsel_s == 2'd2) begin
          state_s = ST_FAULT;
        end else begin
          // Bias removed or moved before the fuse blew; the cell is left intact
          pa_s    = 1'b1;
          state_s = ST_IDLE;
        end
      end
      ST_PROG_OK: begin
        if (same_write_s) begin
          ws_s = WRITING_DONE;
        end else if (nsel_s == 2'd2) begin
          state_s = ST_FAULT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (nsel_s == 2'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ib_s = (state_s == ST_FAULT);
  end

  // State, fuse and output registers; reset clears everything including fuses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      row_r   <= '0;
      col_r   <= '0;
      cnt_r   <= '0;
      fuse_r  <= '0;
      orc_r   <= 1'b0;
      ws_r    <= 1'b0;
      pa_r    <= 1'b0;
      ib_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      col_r   <= col_s;
      cnt_r   <= cnt_s;
      fuse_r  <= fuse_s;
      orc_r   <= orc_s;
      ws_r    <= ws_s;
      pa_r    <= pa_s;
      ib_r    <= ib_s;
    end
  end

  assign output_read_circuit = orc_r;
  assign writing_successful  = ws_r;
  assign prog_abort          = pa_r;
  assign illegal_bias        = ib_r;
  assign fuse_state          = fuse_r;

endmodule

// File: tb/tb_otp_array_model.sv
// Directed scoreboard bench for otp_array_model: a PROG_CYCLES=4 instance and a
// PROG_CYCLES=1 instance share the bias bus; outputs packed as {orc,ws,pa,ib,fuse}.
module tb_otp_array_model;
  import otp_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] PL;
  logic [1:0] BL, WLN, WLP;
  logic       PRG;

  logic       orc0, ws0, pa0, ib0, orc1, ws1, pa1, ib1;
  logic [3:0] fs0, fs1;
  logic [7:0] obs0, obs1;

  typedef struct {
    string      tag;
    bit         which;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign obs0 = {orc0, ws0, pa0, ib0, fs0};
  assign obs1 = {orc1, ws1, pa1, ib1, fs1};

  otp_array_model #(.A(2), .B(2), .PROG_CYCLES(4)) dut (
    .clk (clk), .reset (reset), .PL (PL), .BL (BL), .WLN (WLN), .WLP (WLP), .PRG (PRG),
    .output_read_circuit (orc0), .writing_successful (ws0), .prog_abort (pa0),
    .illegal_bias (ib0), .fuse_state (fs0)
  );

  otp_array_model #(.A(2), .B(2), .PROG_CYCLES(1)) dut1 (
    .clk (clk), .reset (reset), .PL (PL), .BL (BL), .WLN (WLN), .WLP (WLP), .PRG (PRG),
    .output_read_circuit (orc1), .writing_successful (ws1), .prog_abort (pa1),
    .illegal_bias (ib1), .fuse_state (fs1)
  );

  task automatic bias_idle();
    PRG = PRG_READ;
    PL  = 4'b0000;
    BL  = 2'b00;
    WLN = 2'b11;
    WLP = 2'b11;
  endtask

  task automatic bias_write(input int row, input int col);
    logic [1:0] wl;
    logic [1:0] bl;
    logic [3:0] pl;
    wl = 2'b11;
    wl[row] = 1'b0;
    bl = 2'b11;
    bl[col] = 1'b0;
    pl = 4'b0000;
    pl[2*col +: 2] = PL_V_HIGH;
    PRG = PRG_WRITE;
    WLP = wl;
    WLN = wl;
    BL  = bl;
    PL  = pl;
  endtask

  task automatic bias_read(input int row, input int col);
    logic [1:0] wln;
    logic [1:0] bl;
    logic [3:0] pl;
    wln = 2'b11;
    wln[row] = 1'b0;
    bl = 2'b00;
    bl[col] = 1'b1;
    pl = 4'b0000;
    pl[2*col +: 2] = PL_V_READ;
    PRG = PRG_READ;
    WLP = 2'b11;
    WLN = wln;
    BL  = bl;
    PL  = pl;
  endtask

  // Push expectations for the coming edge, clock once, then drain and compare.
  task automatic cyc(input string tag, input logic [7:0] e0, input bit chk1, input logic [7:0] e1);
    exp_t       e;
    logic [7:0] obs;
    e.tag = tag;
    e.which = 1'b0;
    e.exp = e0;
    sb_q.push_back(e);
    if (chk1) begin
      e.tag = {tag, "/pc1"};
      e.which = 1'b1;
      e.exp = e1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = e.which ? obs1 : obs0;
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bias_idle();
    cyc("reset", 8'h00, 1'b1, 8'h00);
    reset = 1'b0;

    // Program [1][0] for four cycles; fuse bit 2 blows on the fourth edge
    bias_write(1, 0);
    cyc("w10_c1", 8'h00, 1'b0, 8'h00);
    cyc("w10_c2", 8'h00, 1'b0, 8'h00);
    cyc("w10_c3", 8'h00, 1'b0, 8'h00);
    cyc("w10_c4", 8'h44, 1'b0, 8'h00);
    bias_idle();
    cyc("w10_release", 8'h04, 1'b0, 8'h00);

    // Three-cycle write on [0][1] aborts
    bias_write(0, 1);
    for (int k = 0; k < 3; k++) cyc("w01_short", 8'h04, 1'b0, 8'h00);
    bias_idle();
    cyc("abort_pulse", 8'h24, 1'b0, 8'h00);
    cyc("abort_clear", 8'h04, 1'b0, 8'h00);

    // Back-to-back reads
    bias_read(1, 0);
    cyc("read10", 8'h84, 1'b0, 8'h00);
    bias_read(0, 0);
    cyc("read00", 8'h04, 1'b0, 8'h00);
    bias_read(1, 0);
    cyc("read10_again", 8'h84, 1'b0, 8'h00);
    bias_idle();
    cyc("read_release", 8'h04, 1'b0, 8'h00);

    // Two rows write-biased on column 0 at once
    PRG = PRG_WRITE;
    WLP = 2'b00;
    WLN = 2'b00;
    BL  = 2'b10;
    PL  = 4'b0011;
    cyc("fault_enter", 8'h14, 1'b0, 8'h00);
    cyc("fault_hold", 8'h14, 1'b0, 8'h00);
    bias_idle();
    cyc("fault_exit", 8'h04, 1'b0, 8'h00);

    // Re-programming a blown cell runs the full sequence and leaves it blown
    bias_write(1, 0);
    for (int k = 0; k < 3; k++) cyc("reprog", 8'h04, 1'b0, 8'h00);
    cyc("reprog_done", 8'h44, 1'b0, 8'h00);
    bias_idle();
    cyc("reprog_release", 8'h04, 1'b0, 8'h00);

    // Reset during the second cycle of a write to [0][0]
    bias_write(0, 0);
    cyc("w00_c1", 8'h04, 1'b0, 8'h00);
    reset = 1'b1;
    cyc("reset_mid", 8'h00, 1'b1, 8'h00);
    reset = 1'b0;
    bias_idle();
    cyc("after_reset", 8'h00, 1'b1, 8'h00);

    // Single write cycle on [1][1]: blows at once only in the PROG_CYCLES=1 build
    bias_write(1, 1);
    cyc("pc1_write", 8'h00, 1'b1, 8'h48);
    bias_idle();
    cyc("pc1_release", 8'h20, 1'b1, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
